// File: rtl/sgpr_vote_comparator.sv
// Registered 2-/3-way voter for the shared GPR write port of a lockstep cluster.
// Forwards the agreed or majority write tuple, flags the suspect channel and escalates persistent faults.
module sgpr_vote_comparator #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int NUM_CH          = 3,
    parameter int FAULT_THRESHOLD = 3,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            we_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
    output logic                         we_o,
    output logic [ADDR_WIDTH-1:0]        addr_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         mismatch_o,
    output logic                         uncorrectable_o,
    output logic [NUM_CH-1:0]            faulty_ch_o,
    output logic                         recover_req_o,
    input  logic                         recover_ack_i,
    input  logic                         clr_cnt_i,
    output logic [CNT_WIDTH-1:0]         err_cnt_o
);

    if (!(NUM_CH == 2 || NUM_CH == 3)) begin : g_bad_num_ch
        $error("sgpr_vote_comparator: NUM_CH must be 2 or 3");
    end
    if (FAULT_THRESHOLD < 1 || FAULT_THRESHOLD > 15) begin : g_bad_threshold
        $error("sgpr_vote_comparator: FAULT_THRESHOLD must be in 1..15");
    end

    localparam logic [3:0] STRIKE_LIMIT = 4'(FAULT_THRESHOLD);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    // Two channels agree when neither writes, or when the whole tuple matches.
    function automatic logic ch_eq(
        input logic                  we_a,
        input logic                  we_b,
        input logic [ADDR_WIDTH-1:0] addr_a,
        input logic [ADDR_WIDTH-1:0] addr_b,
        input logic [DATA_WIDTH-1:0] data_a,
        input logic [DATA_WIDTH-1:0] data_b
    );
        return (!we_a && !we_b) || (we_a == we_b && addr_a == addr_b && data_a == data_b);
    endfunction

    logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign ch_addr[c] = addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        assign ch_data[c] = data_i[c*DATA_WIDTH +: DATA_WIDTH];
    end

    logic                  vote_we;
    logic [ADDR_WIDTH-1:0] vote_addr;
    logic [DATA_WIDTH-1:0] vote_data;
    logic                  vote_mis;
    logic                  vote_unc;
    logic [NUM_CH-1:0]     suspect;

    if (NUM_CH == 2) begin : g_dmr
        logic eq01;
        assign eq01 = ch_eq(we_i[0], we_i[1], ch_addr[0], ch_addr[1], ch_data[0], ch_data[1]);

        // Any disagreement between two channels cannot be localised.
        always_comb begin
            vote_we   = we_i[0] & eq01;
            vote_addr = ch_addr[0];
            vote_data = ch_data[0];
            vote_mis  = ~eq01;
            vote_unc  = ~eq01;
            suspect   = '0;
        end
    end else begin : g_tmr
        logic eq01;
        logic eq02;
        logic eq12;
        assign eq01 = ch_eq(we_i[0], we_i[1], ch_addr[0], ch_addr[1], ch_data[0], ch_data[1]);
        assign eq02 = ch_eq(we_i[0], we_i[2], ch_addr[0], ch_addr[2], ch_data[0], ch_data[2]);
        assign eq12 = ch_eq(we_i[1], we_i[2], ch_addr[1], ch_addr[2], ch_data[1], ch_data[2]);

        // Equality is transitive, so at most one pair can match when not all three do.
        always_comb begin
            vote_we   = we_i[0];
            vote_addr = ch_addr[0];
            vote_data = ch_data[0];
            vote_mis  = 1'b0;
            vote_unc  = 1'b0;
            suspect   = '0;
            if (!(eq01 && eq02)) begin
                vote_mis = 1'b1;
                if (eq01) begin
                    suspect[2] = 1'b1;
                end else if (eq02) begin
                    suspect[1] = 1'b1;
                end else if (eq12) begin
                    suspect[0] = 1'b1;
                    vote_we    = we_i[1];
                    vote_addr  = ch_addr[1];
                    vote_data  = ch_data[1];
                end else begin
                    vote_unc = 1'b1;
                    vote_we  = 1'b0;
                end
            end
        end
    end

    logic                  all_idle;
    logic                  agree_active;

    assign all_idle     = ~|we_i;
    assign agree_active = ~vote_mis & ~all_idle;

    logic                  we_d,       we_q;
    logic [ADDR_WIDTH-1:0] addr_d,     addr_q;
    logic [DATA_WIDTH-1:0] data_d,     data_q;
    logic                  mismatch_d, mismatch_q;
    logic                  uncorr_d,   uncorr_q;
    logic [NUM_CH-1:0]     faulty_d,   faulty_q;
    logic [3:0]            strike_d,   strike_q;
    logic [CNT_WIDTH-1:0]  cnt_d,      cnt_q;
    state_e                state_d,    state_q;

    // Datapath: address and data only move on an actual voted write.
    always_comb begin
        we_d       = vote_we;
        addr_d     = vote_we ? vote_addr : addr_q;
        data_d     = vote_we ? vote_data : data_q;
        mismatch_d = vote_mis;
        uncorr_d   = vote_unc;

        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (vote_mis && cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Strike FSM; the counter and suspect are frozen while recovery is pending.
    always_comb begin
        state_d  = state_q;
        strike_d = strike_q;
        faulty_d = faulty_q;
        case (state_q)
            ST_FAULT: begin
                if (recover_ack_i) begin
                    state_d  = ST_OK;
                    strike_d = '0;
                    faulty_d = '0;
                end
            end
            default: begin
                if (vote_unc) begin
                    state_d = ST_FAULT;
                end else if (vote_mis) begin
                    if (suspect == faulty_q) begin
                        strike_d = (strike_q == 4'hF) ? strike_q : strike_q + 4'd1;
                    end else begin
                        strike_d = 4'd1;
                        faulty_d = suspect;
                    end
                    state_d = (strike_d >= STRIKE_LIMIT) ? ST_FAULT : ST_SUSPECT;
                end else if (agree_active) begin
                    strike_d = '0;
                    state_d  = ST_OK;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mismatch_q <= 1'b0;
            uncorr_q   <= 1'b0;
            faulty_q   <= '0;
            strike_q   <= '0;
            cnt_q      <= '0;
            state_q    <= ST_OK;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mismatch_q <= mismatch_d;
            uncorr_q   <= uncorr_d;
            faulty_q   <= faulty_d;
            strike_q   <= strike_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign we_o            = we_q;
    assign addr_o          = addr_q;
    assign data_o          = data_q;
    assign mismatch_o      = mismatch_q;
    assign uncorrectable_o = uncorr_q;
    assign faulty_ch_o     = faulty_q;
    assign recover_req_o   = (state_q == ST_FAULT);
    assign err_cnt_o       = cnt_q;

endmodule

// File: tb/tb_sgpr_vote_comparator.sv
// Bench for sgpr_vote_comparator: TMR, DMR and a narrow-counter TMR instance driven from a vector table.
module tb_sgpr_vote_comparator;

    localparam logic [31:0] DE = 32'hDEADBEEF;
    localparam logic [31:0] DF = 32'hDEADBEEE;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // TMR instance inputs (shared with the narrow-counter instance)
    logic [2:0]  a_we;
    logic [14:0] a_addr;
    logic [95:0] a_data;
    logic        a_ack, a_clr;
    logic        a_we_o, a_mis, a_unc, a_req;
    logic [4:0]  a_addr_o;
    logic [31:0] a_data_o;
    logic [2:0]  a_faulty;
    logic [15:0] a_cnt;

    logic        c_we_o, c_mis, c_unc, c_req;
    logic [4:0]  c_addr_o;
    logic [31:0] c_data_o;
    logic [2:0]  c_faulty;
    logic [1:0]  c_cnt;

    // DMR instance
    logic [1:0]  b_we;
    logic [9:0]  b_addr;
    logic [63:0] b_data;
    logic        b_ack, b_clr;
    logic        b_we_o, b_mis, b_unc, b_req;
    logic [4:0]  b_addr_o;
    logic [31:0] b_data_o;
    logic [1:0]  b_faulty;
    logic [15:0] b_cnt;

    sgpr_vote_comparator #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_CH(3), .FAULT_THRESHOLD(3), .CNT_WIDTH(16)) u_tmr (
        .clk_i(clk), .rst_ni(rst_n), .we_i(a_we), .addr_i(a_addr), .data_i(a_data),
        .we_o(a_we_o), .addr_o(a_addr_o), .data_o(a_data_o), .mismatch_o(a_mis),
        .uncorrectable_o(a_unc), .faulty_ch_o(a_faulty), .recover_req_o(a_req),
        .recover_ack_i(a_ack), .clr_cnt_i(a_clr), .err_cnt_o(a_cnt));

    sgpr_vote_comparator #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_CH(3), .FAULT_THRESHOLD(3), .CNT_WIDTH(2)) u_tmr_c2 (
        .clk_i(clk), .rst_ni(rst_n), .we_i(a_we), .addr_i(a_addr), .data_i(a_data),
        .we_o(c_we_o), .addr_o(c_addr_o), .data_o(c_data_o), .mismatch_o(c_mis),
        .uncorrectable_o(c_unc), .faulty_ch_o(c_faulty), .recover_req_o(c_req),
        .recover_ack_i(a_ack), .clr_cnt_i(a_clr), .err_cnt_o(c_cnt));

    sgpr_vote_comparator #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_CH(2), .FAULT_THRESHOLD(3), .CNT_WIDTH(16)) u_dmr (
        .clk_i(clk), .rst_ni(rst_n), .we_i(b_we), .addr_i(b_addr), .data_i(b_data),
        .we_o(b_we_o), .addr_o(b_addr_o), .data_o(b_data_o), .mismatch_o(b_mis),
        .uncorrectable_o(b_unc), .faulty_ch_o(b_faulty), .recover_req_o(b_req),
        .recover_ack_i(b_ack), .clr_cnt_i(b_clr), .err_cnt_o(b_cnt));

    typedef struct {
        logic        sel;      // 0: TMR pair, 1: DMR
        logic [2:0]  we;
        logic [14:0] addr;
        logic [95:0] data;
        logic        ack;
        logic        clr;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic        emis;
        logic        eunc;
        logic [2:0]  efaulty;
        logic        ereq;
        logic [15:0] ecnt;
        logic [1:0]  ecntc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int sel, input int we, input int a0, input int a1, input int a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input int ack, input int clr, input int ewe, input int ea,
                                input logic [31:0] ed, input int emis, input int eunc, input int ef,
                                input int ereq, input int ecnt, input int ecntc);
        vec_t v;
        v.sel     = 1'(sel);
        v.we      = 3'(we);
        v.addr    = {5'(a2), 5'(a1), 5'(a0)};
        v.data    = {d2, d1, d0};
        v.ack     = 1'(ack);
        v.clr     = 1'(clr);
        v.ewe     = 1'(ewe);
        v.eaddr   = 5'(ea);
        v.edata   = ed;
        v.emis    = 1'(emis);
        v.eunc    = 1'(eunc);
        v.efaulty = 3'(ef);
        v.ereq    = 1'(ereq);
        v.ecnt    = 16'(ecnt);
        v.ecntc   = 2'(ecntc);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic compare(input vec_t v, input int idx);
        if (!v.sel) begin
            chk("tmr we_o", idx, 32'(a_we_o), 32'(v.ewe));
            chk("tmr addr_o", idx, 32'(a_addr_o), 32'(v.eaddr));
            chk("tmr data_o", idx, a_data_o, v.edata);
            chk("tmr mismatch_o", idx, 32'(a_mis), 32'(v.emis));
            chk("tmr uncorrectable_o", idx, 32'(a_unc), 32'(v.eunc));
            chk("tmr faulty_ch_o", idx, 32'(a_faulty), 32'(v.efaulty));
            chk("tmr recover_req_o", idx, 32'(a_req), 32'(v.ereq));
            chk("tmr err_cnt_o", idx, 32'(a_cnt), 32'(v.ecnt));
            chk("cnt2 err_cnt_o", idx, 32'(c_cnt), 32'(v.ecntc));
        end else begin
            chk("dmr we_o", idx, 32'(b_we_o), 32'(v.ewe));
            chk("dmr addr_o", idx, 32'(b_addr_o), 32'(v.eaddr));
            chk("dmr data_o", idx, b_data_o, v.edata);
            chk("dmr mismatch_o", idx, 32'(b_mis), 32'(v.emis));
            chk("dmr uncorrectable_o", idx, 32'(b_unc), 32'(v.eunc));
            chk("dmr faulty_ch_o", idx, 32'(b_faulty), 32'(v.efaulty));
            chk("dmr recover_req_o", idx, 32'(b_req), 32'(v.ereq));
            chk("dmr err_cnt_o", idx, 32'(b_cnt), 32'(v.ecnt));
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        if (!v.sel) begin
            a_we = v.we; a_addr = v.addr; a_data = v.data; a_ack = v.ack; a_clr = v.clr;
            b_we = '0; b_addr = '0; b_data = '0; b_ack = 1'b0; b_clr = 1'b0;
        end else begin
            b_we = v.we[1:0]; b_addr = v.addr[9:0]; b_data = v.data[63:0]; b_ack = v.ack; b_clr = v.clr;
            a_we = '0; a_addr = '0; a_data = '0; a_ack = 1'b0; a_clr = 1'b0;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard (step %0d): queue empty", idx);
        end else begin
            e = exp_q.pop_front();
            compare(e, idx);
        end
    endtask

    task automatic chk_tmr_zero(input string nm);
        chk({nm, " we_o"}, 0, 32'(a_we_o), 32'd0);
        chk({nm, " addr_o"}, 0, 32'(a_addr_o), 32'd0);
        chk({nm, " data_o"}, 0, a_data_o, 32'd0);
        chk({nm, " mismatch_o"}, 0, 32'(a_mis), 32'd0);
        chk({nm, " uncorrectable_o"}, 0, 32'(a_unc), 32'd0);
        chk({nm, " faulty_ch_o"}, 0, 32'(a_faulty), 32'd0);
        chk({nm, " recover_req_o"}, 0, 32'(a_req), 32'd0);
        chk({nm, " err_cnt_o"}, 0, 32'(a_cnt), 32'd0);
        chk({nm, " cnt2 err_cnt_o"}, 0, 32'(c_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_we = '0; a_addr = '0; a_data = '0; a_ack = 1'b0; a_clr = 1'b0;
        b_we = '0; b_addr = '0; b_data = '0; b_ack = 1'b0; b_clr = 1'b0;

        // TMR: sel we a0 a1 a2 d0 d1 d2 ack clr | ewe ea ed mis unc faulty req cnt cnt2
        vecs.push_back(mk(0, 'b111, 5, 5, 5, DE, DE, DE, 0, 0, 1, 5, DE, 0, 0, 'b000, 0, 0, 0));
        vecs.push_back(mk(0, 'b111, 5, 5, 5, DE, DF, DE, 0, 0, 1, 5, DE, 1, 0, 'b010, 0, 1, 1));
        vecs.push_back(mk(0, 'b111, 7, 7, 7, 32'h11111111, 32'h11111111, 32'h11111111, 0, 0, 1, 7, 32'h11111111, 0, 0, 'b010, 0, 1, 1));
        vecs.push_back(mk(0, 'b111, 8, 8, 8, 32'h22222222, 32'h22222222, 32'h02222222, 0, 0, 1, 8, 32'h22222222, 1, 0, 'b100, 0, 2, 2));
        vecs.push_back(mk(0, 'b111, 9, 9, 9, 32'h33333333, 32'h33333333, 32'h03333333, 0, 0, 1, 9, 32'h33333333, 1, 0, 'b100, 0, 3, 3));
        vecs.push_back(mk(0, 'b000, 1, 2, 3, 1, 2, 3, 0, 0, 0, 9, 32'h33333333, 0, 0, 'b100, 0, 3, 3));
        vecs.push_back(mk(0, 'b111, 10, 10, 10, 32'h44444444, 32'h44444444, 32'h04444444, 0, 0, 1, 10, 32'h44444444, 1, 0, 'b100, 1, 4, 3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 32'h44444444, 0, 0, 'b100, 1, 4, 3));
        vecs.push_back(mk(0, 'b111, 11, 11, 11, 32'h55555554, 32'h55555555, 32'h55555555, 0, 0, 1, 11, 32'h55555555, 1, 0, 'b100, 1, 5, 3));
        vecs.push_back(mk(0, 'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11, 32'h55555555, 0, 0, 'b100, 1, 5, 3));
        vecs.push_back(mk(0, 'b111, 12, 12, 12, 32'h66666666, 32'h66666667, 32'h66666666, 1, 0, 1, 12, 32'h66666666, 1, 0, 'b000, 0, 6, 3));
        vecs.push_back(mk(0, 'b111, 13, 13, 13, 32'h77777777, 32'h77777778, 32'h77777777, 0, 0, 1, 13, 32'h77777777, 1, 0, 'b010, 0, 7, 3));
        vecs.push_back(mk(0, 'b111, 14, 14, 14, 32'h88888888, 32'h88888889, 32'h88888888, 1, 0, 1, 14, 32'h88888888, 1, 0, 'b010, 0, 8, 3));
        vecs.push_back(mk(0, 'b111, 15, 15, 15, 32'h99999999, 32'h9999999A, 32'h99999999, 0, 0, 1, 15, 32'h99999999, 1, 0, 'b010, 1, 9, 3));
        vecs.push_back(mk(0, 'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 15, 32'h99999999, 0, 0, 'b000, 0, 9, 3));
        vecs.push_back(mk(0, 'b111, 1, 2, 3, 0, 0, 0, 0, 0, 0, 15, 32'h99999999, 1, 1, 'b000, 1, 10, 3));
        vecs.push_back(mk(0, 'b111, 2, 2, 2, 32'hBBBBBBBB, 32'hBBBBBBBC, 32'hBBBBBBBB, 1, 1, 1, 2, 32'hBBBBBBBB, 1, 0, 'b000, 0, 0, 0));
        vecs.push_back(mk(0, 'b011, 4, 4, 4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, 0, 1, 4, 32'hAAAAAAAA, 1, 0, 'b100, 0, 1, 1));
        vecs.push_back(mk(0, 'b100, 4, 4, 4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, 0, 0, 4, 32'hAAAAAAAA, 1, 0, 'b100, 0, 2, 2));
        vecs.push_back(mk(0, 'b000, 6, 7, 8, 1, 2, 3, 0, 0, 0, 4, 32'hAAAAAAAA, 0, 0, 'b100, 0, 2, 2));
        vecs.push_back(mk(0, 'b111, 1, 2, 3, 0, 0, 0, 0, 0, 0, 4, 32'hAAAAAAAA, 1, 1, 'b100, 1, 3, 3));
        // DMR
        vecs.push_back(mk(1, 'b011, 3, 3, 0, 32'h12345678, 32'h12345678, 0, 0, 0, 1, 3, 32'h12345678, 0, 0, 'b000, 0, 0, 0));
        vecs.push_back(mk(1, 'b001, 3, 3, 0, 32'h12345678, 32'h12345678, 0, 0, 0, 0, 3, 32'h12345678, 1, 1, 'b000, 1, 1, 0));
        vecs.push_back(mk(1, 'b000, 6, 7, 0, 1, 2, 0, 0, 0, 0, 3, 32'h12345678, 0, 0, 'b000, 1, 1, 0));
        vecs.push_back(mk(1, 'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 32'h12345678, 0, 0, 'b000, 0, 1, 0));
        vecs.push_back(mk(1, 'b011, 9, 9, 0, 5, 6, 0, 0, 0, 0, 3, 32'h12345678, 1, 1, 'b000, 1, 2, 0));
        vecs.push_back(mk(1, 'b011, 9, 9, 0, 7, 7, 0, 1, 1, 1, 9, 7, 0, 0, 'b000, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk_tmr_zero("reset");
        chk("reset dmr we_o", 0, 32'(b_we_o), 32'd0);
        chk("reset dmr recover_req_o", 0, 32'(b_req), 32'd0);
        chk("reset dmr err_cnt_o", 0, 32'(b_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Reset while the TMR is in FAULT with a write in flight.
        @(negedge clk);
        a_we = 3'b111; a_addr = {5'd5, 5'd5, 5'd5}; a_data = {32'h1, 32'h1, 32'h1};
        b_we = '0; b_addr = '0; b_data = '0; b_ack = 1'b0; b_clr = 1'b0;
        chk("pre-reset recover_req_o", 0, 32'(a_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_tmr_zero("async reset");
        @(posedge clk);
        #1;
        chk("reset inflight we_o", 0, 32'(a_we_o), 32'd0);
        chk("reset inflight data_o", 0, a_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_we = '0; a_addr = '0; a_data = '0;
        @(posedge clk);
        #1;
        chk("post-reset recover_req_o", 0, 32'(a_req), 32'd0);
        chk("post-reset mismatch_o", 0, 32'(a_mis), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sgpr_vote_comparator.md
Name: sgpr_vote_comparator

Overview:
Registered N-way comparator/voter for the shared GPR write port of a lockstep core cluster (2-core DMR or 3-core TMR). Each cycle it compares the per-core write tuples {we, addr, data} and forwards the agreed or majority tuple to the register file. It flags the faulty channel and counts errors. A strike FSM raises a recovery request once a channel persistently disagrees.

Parameters:
DATA_WIDTH, 32, width of write data per channel
ADDR_WIDTH, 5, width of register address per channel
NUM_CH, 3, number of channels; legal values 2 or 3 only, elaboration error otherwise
FAULT_THRESHOLD, 3, mismatches on the same channel that escalate to FAULT; legal range 1..15
CNT_WIDTH, 16, width of the saturating error counter

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
we_i  in  NUM_CH  per-channel write enable; bit c is channel c
addr_i  in  NUM_CH*ADDR_WIDTH  per-channel address; channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
data_i  in  NUM_CH*DATA_WIDTH  per-channel data; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
we_o  out  1  voted write enable to the register file
addr_o  out  ADDR_WIDTH  voted address
data_o  out  DATA_WIDTH  voted data
mismatch_o  out  1  one-cycle pulse: the tuple on the outputs had a disagreement
uncorrectable_o  out  1  one-cycle pulse: no majority exists; write suppressed
faulty_ch_o  out  NUM_CH  one-hot suspect channel; held until recovery or a new suspect
recover_req_o  out  1  level request for core resynchronisation; FSM is in FAULT
recover_ack_i  in  1  recovery done; sampled only in FAULT
clr_cnt_i  in  1  synchronous clear of err_cnt_o
err_cnt_o  out  CNT_WIDTH  saturating count of mismatch events

Behaviour:
- Reset (rst_ni=0, async): all outputs are 0, FSM is OK, strike counter is 0.
- Latency: 1 cycle. Inputs sampled at edge k appear on we_o/addr_o/data_o and on the flags after edge k.
- Channel equality: when both channels have we=0, they are equal regardless of addr and data. Otherwise they are equal only when we, addr and data all match.
- Idle cycle (all we_i=0): counts as agreement. Outputs we_o=0; addr_o and data_o hold their previous values. No strike change.
- NUM_CH=2, channels equal: forward the tuple; mismatch_o=0.
- NUM_CH=2, channels differ:
  - we_o=0; addr_o and data_o hold.
  - mismatch_o=1 and uncorrectable_o=1.
  - faulty_ch_o is unchanged; the fault cannot be localised with two channels.
  - FSM goes to FAULT directly.
- NUM_CH=3, all three equal: forward the tuple.
- NUM_CH=3, exactly one channel differs from the other two:
  - Forward the majority tuple; write proceeds.
  - mismatch_o=1.
  - The odd channel is the suspect.
- NUM_CH=3, all three pairwise different: we_o=0, mismatch_o=1, uncorrectable_o=1, FSM goes to FAULT.
- Strike counter (4 bits), in state OK or SUSPECT:
  - Mismatch whose suspect equals faulty_ch_o: increment.
  - Mismatch with a new suspect: load 1 and update faulty_ch_o.
  - Non-idle full agreement: clear the counter, go to OK; faulty_ch_o holds.
- FSM, state OK:
  - Correctable mismatch goes to SUSPECT (or to FAULT if FAULT_THRESHOLD=1).
  - Uncorrectable mismatch goes to FAULT.
- FSM, state SUSPECT:
  - Strike counter reaching FAULT_THRESHOLD goes to FAULT.
  - Non-idle agreement goes to OK.
  - Uncorrectable mismatch goes to FAULT.
- FSM, state FAULT:
  - recover_req_o=1 while in FAULT; it rises in the same cycle as the escalating mismatch_o pulse.
  - Voting and forwarding continue unchanged; the strike counter is frozen.
  - recover_ack_i=1 goes to OK on the next cycle and clears the strike counter and faulty_ch_o.
- Ack together with a new mismatch: the ack wins. Go to OK with the strike counter at 0; the mismatch is counted in err_cnt_o only.
- recover_ack_i outside FAULT: ignored.
- err_cnt_o:
  - +1 per mismatch_o pulse; saturates at all-ones.
  - clr_cnt_i sets it to 0 on the next edge. A clear in the same cycle as a mismatch gives 0 (clear wins).
- Reset mid-operation: immediate return to reset values. An in-flight tuple is dropped; we_o=0.

Test Plan:
- NUM_CH=3; all channels we=1, addr=5, data=0xDEADBEEF -> next cycle we_o=1, addr_o=5, data_o=0xDEADBEEF, mismatch_o=0, err_cnt_o=0.
- NUM_CH=3; ch1 data=0xDEADBEEE, others 0xDEADBEEF -> data_o=0xDEADBEEF, we_o=1, mismatch_o pulse, faulty_ch_o=3'b010, err_cnt_o=1, state SUSPECT.
- NUM_CH=3, FAULT_THRESHOLD=3; ch2 wrong on 3 consecutive writes -> recover_req_o=1 after the third; it stays high through 5 idle cycles; recover_ack_i pulse -> next cycle recover_req_o=0, faulty_ch_o=0, err_cnt_o=3.
- NUM_CH=3; addr=1/2/3 on the three channels -> we_o=0, uncorrectable_o=1, recover_req_o=1 in the same cycle.
- NUM_CH=2; we 1 vs 0 -> we_o=0, mismatch_o=1, uncorrectable_o=1, recover_req_o=1.
- NUM_CH=2; we=0 on both with differing addr/data -> no mismatch.
- CNT_WIDTH=2; 5 mismatches -> err_cnt_o saturates at 3.
- Then clr_cnt_i together with a mismatch -> err_cnt_o=0.
- Assert rst_ni low mid-FAULT -> all outputs 0 immediately.
